// File: rtl/sub_tc_pkg.sv
// Shared definitions for the sequential 16-bit two's-complement subtractor:
// FSM state encoding, operand/result widths and the digit-width legality check.
package sub_tc_pkg;

  localparam int OPW  = 16;
  localparam int RESW = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit digit_w_legal(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16);
  endfunction

endpackage

// File: rtl/sub_tc_digit.sv
// Combinational W-bit full adder with carry in/out; one digit of the
// serial subtraction per compute cycle.
module sub_tc_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

endmodule

// File: rtl/sub_tc_16_16_seq.sv
// Digit-serial 16-bit two's-complement subtractor, diff = a - b (17 bits).
// Optional saturation to the 16-bit range is enabled by defining SUB_TC_SAT_EN.
module sub_tc_16_16_seq
  import sub_tc_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RESW-1:0] diff,
`ifdef SUB_TC_SAT_EN
  output logic            sat,
`endif
  output logic            busy
);

  localparam int         N        = OPW / DIGIT_W;
  localparam logic [4:0] LAST_IDX = 5'(N - 1);

  if (!digit_w_legal(DIGIT_W)) begin : g_bad_digit_w
    $error("sub_tc_16_16_seq: DIGIT_W must be 1, 2, 4, 8 or 16");
  end

  state_e          state_q, state_d;
  logic [OPW-1:0]  a_q, a_d;
  logic [OPW-1:0]  b_q, b_d;
  logic [OPW-1:0]  acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [4:0]      idx_q, idx_d;
  logic [RESW-1:0] diff_q, diff_d;
`ifdef SUB_TC_SAT_EN
  logic            sat_q, sat_d;
  logic            ovf;
`endif

  int                 bit_lo;
  logic [DIGIT_W-1:0] dig_a, dig_nb, dig_sum;
  logic               dig_cout;
  logic [OPW-1:0]     acc_next;
  logic [RESW-1:0]    exact, result;

  assign bit_lo = int'(idx_q) * DIGIT_W;
  assign dig_a  = a_q[bit_lo +: DIGIT_W];
  assign dig_nb = ~b_q[bit_lo +: DIGIT_W];

  sub_tc_digit #(.W(DIGIT_W)) u_digit (
    .x    (dig_a),
    .y    (dig_nb),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    acc_next                    = acc_q;
    acc_next[bit_lo +: DIGIT_W] = dig_sum;
    // Sign bit of the 17-bit sum sext(a) + sext(~b) + 1.
    exact  = {a_q[OPW-1] ^ ~b_q[OPW-1] ^ dig_cout, acc_next};
`ifdef SUB_TC_SAT_EN
    ovf    = exact[RESW-1] ^ exact[RESW-2];
    result = ovf ? (exact[RESW-1] ? 17'h18000 : 17'h07FFF) : exact;
`else
    result = exact;
`endif

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
`ifdef SUB_TC_SAT_EN
    sat_d   = sat_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_next;
        carry_d = dig_cout;
        idx_d   = idx_q + 5'd1;
        if (idx_q == LAST_IDX) begin
          diff_d  = result;
`ifdef SUB_TC_SAT_EN
          sat_d   = ovf;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
`ifdef SUB_TC_SAT_EN
          sat_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop. All registers here are
  // small and are cleared by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      diff_q  <= '0;
`ifdef SUB_TC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
`ifdef SUB_TC_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign diff      = diff_q;
`ifdef SUB_TC_SAT_EN
  assign sat       = sat_q;
`endif

endmodule

// File: tb/tb_sub_tc_16_16_seq.sv
// Directed bench for sub_tc_16_16_seq; three instances cover DIGIT_W = 1, 4, 16.
// Define SUB_TC_SAT_EN for both RTL and bench to exercise the saturating build.
module tb_sub_tc_16_16_seq;

  logic clk = 1'b0;
  logic rstn;

  logic [2:0]        in_valid_s, out_ready_s;
  logic [2:0][15:0]  a_s, b_s;
  logic [2:0]        in_ready_s, out_valid_s, busy_s;
  logic [2:0][16:0]  diff_s;
`ifdef SUB_TC_SAT_EN
  logic [2:0]        sat_s;
`endif

  int vecs = 0;
  int errs = 0;

  function automatic int dw_of(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sub_tc_16_16_seq #(.DIGIT_W(dw_of(g))) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .diff      (diff_s[g]),
`ifdef SUB_TC_SAT_EN
      .sat       (sat_s[g]),
`endif
      .busy      (busy_s[g])
    );
  end

  always #5 clk = ~clk;

  // Checks the idle-after-reset/handshake output state of instance d.
  task automatic check_idle(input int d, input string nm, input bit diff_zero);
    vecs++;
    if (in_ready_s[d] !== 1'b1 || out_valid_s[d] !== 1'b0 || busy_s[d] !== 1'b0) begin
      errs++;
      $display("FAIL %s dw=%0d: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               nm, dw_of(d), in_ready_s[d], out_valid_s[d], busy_s[d]);
    end
    if (diff_zero) begin
      vecs++;
      if (diff_s[d] !== 17'h0) begin
        errs++;
        $display("FAIL %s dw=%0d: diff=%h want 00000", nm, dw_of(d), diff_s[d]);
      end
    end
`ifdef SUB_TC_SAT_EN
    vecs++;
    if (sat_s[d] !== 1'b0) begin
      errs++;
      $display("FAIL %s dw=%0d: sat=%b want 0", nm, dw_of(d), sat_s[d]);
    end
`endif
  endtask

  // Called at the negedge right after the accepting edge. Measures latency,
  // checks the result, holds out_ready low for hold cycles, then handshakes.
  task automatic wait_result(input int d, input logic [16:0] exp, input logic exp_sat,
                             input int hold, input string nm);
    int cnt = 0;
    while (out_valid_s[d] !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    vecs++;
    if (out_valid_s[d] !== 1'b1) begin
      errs++;
      $display("FAIL %s dw=%0d: out_valid timeout after %0d cycles", nm, dw_of(d), cnt);
      return;
    end
    vecs++;
    if (cnt != 16 / dw_of(d)) begin
      errs++;
      $display("FAIL %s dw=%0d: latency=%0d want %0d", nm, dw_of(d), cnt, 16 / dw_of(d));
    end
    for (int i = 0; i <= hold; i++) begin
      vecs++;
      if (diff_s[d] !== exp || out_valid_s[d] !== 1'b1 || in_ready_s[d] !== 1'b0
          || busy_s[d] !== 1'b1) begin
        errs++;
        $display("FAIL %s dw=%0d cyc%0d: diff=%h ov=%b ir=%b busy=%b, want diff=%h 1 0 1",
                 nm, dw_of(d), i, diff_s[d], out_valid_s[d], in_ready_s[d], busy_s[d], exp);
      end
`ifdef SUB_TC_SAT_EN
      vecs++;
      if (sat_s[d] !== exp_sat) begin
        errs++;
        $display("FAIL %s dw=%0d: sat=%b want %b", nm, dw_of(d), sat_s[d], exp_sat);
      end
`endif
      if (i < hold) @(negedge clk);
    end
    out_ready_s[d] = 1'b1;
    @(negedge clk);
    out_ready_s[d] = 1'b0;
    check_idle(d, {nm, "_handshake"}, 1'b0);
  endtask

  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] exp, input logic exp_sat, input int hold,
                        input string nm);
    @(negedge clk);
    a_s[d] = a;
    b_s[d] = b;
    in_valid_s[d] = 1'b1;
    @(negedge clk);
    in_valid_s[d] = 1'b0;
    wait_result(d, exp, exp_sat, hold, nm);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    for (int d = 0; d < 3; d++) check_idle(d, "reset", 1'b1);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_vectors();
    logic [15:0] va [6] = '{16'h0005, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234, 16'h8000};
    logic [15:0] vb [6] = '{16'h0003, 16'h0001, 16'h8000, 16'hFFFF, 16'h5678, 16'h7FFF};
`ifdef SUB_TC_SAT_EN
    logic [16:0] ve [6] = '{17'h00002, 17'h18000, 17'h07FFF, 17'h00000, 17'h1BBBC, 17'h18000};
    logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    logic [16:0] ve [6] = '{17'h00002, 17'h17FFF, 17'h0FFFF, 17'h00000, 17'h1BBBC, 17'h10001};
    logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int d = 0; d < 3; d++)
      for (int v = 0; v < 6; v++)
        run_op(d, va[v], vb[v], ve[v], vs[v], 0, $sformatf("vec%0d", v));
  endtask

  task automatic test_hold();
    for (int d = 0; d < 3; d++) run_op(d, 16'h0005, 16'h0003, 17'h00002, 1'b0, 10, "hold");
  endtask

  task automatic test_ignore_busy();
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      a_s[d] = 16'h0005;
      b_s[d] = 16'h0003;
      in_valid_s[d] = 1'b1;
      @(negedge clk);
      a_s[d] = 16'h1234;
      b_s[d] = 16'h0F0F;
      @(negedge clk);
      in_valid_s[d] = 1'b0;
      // One cycle was spent with the ignored pulse; resume counting from there.
      begin
        int cnt = 1;
        while (out_valid_s[d] !== 1'b1 && cnt < 40) begin
          @(negedge clk);
          cnt++;
        end
        vecs++;
        if (out_valid_s[d] !== 1'b1 || diff_s[d] !== 17'h00002 || cnt != 16 / dw_of(d)) begin
          errs++;
          $display("FAIL ignore dw=%0d: ov=%b diff=%h lat=%0d, want 1 00002 %0d",
                   dw_of(d), out_valid_s[d], diff_s[d], cnt, 16 / dw_of(d));
        end
      end
      out_ready_s[d] = 1'b1;
      @(negedge clk);
      out_ready_s[d] = 1'b0;
      check_idle(d, "ignore_handshake", 1'b0);
    end
  endtask

  task automatic test_abort();
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      a_s[d] = 16'h0005;
      b_s[d] = 16'h0003;
      in_valid_s[d] = 1'b1;
      @(negedge clk);
      in_valid_s[d] = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check_idle(d, "abort", 1'b1);
      a_s[d] = 16'hFFFF;
      b_s[d] = 16'hFFFF;
      in_valid_s[d] = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      in_valid_s[d] = 1'b0;
      vecs++;
      if (busy_s[d] !== 1'b1 && out_valid_s[d] !== 1'b1) begin
        errs++;
        $display("FAIL abort_accept dw=%0d: busy=%b want 1", dw_of(d), busy_s[d]);
      end
      wait_result(d, 17'h00000, 1'b0, 0, "abort_next");
    end
  endtask

  initial begin
    in_valid_s  = '0;
    out_ready_s = '0;
    a_s         = '0;
    b_s         = '0;
    test_reset();
    test_vectors();
    test_hold();
    test_ignore_busy();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
